// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding and default geometry for the board renderer
package draw_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 20;
  localparam int HIDDEN_ROWS = 4;
  localparam int CELL_SIZE   = 4;
  localparam int X_START     = 59;
  localparam int Y_START     = 11;
  localparam int COLOUR_W    = 6;

  localparam logic [COLOUR_W-1:0] BLACK = '0;

endpackage

// File: rtl/board_scan_counter.sv
// rtl/board_scan_counter.sv - nested ox/oy/col/row scan counters with clamped row window
module board_scan_counter #(
  parameter int BOARD_W   = draw_pkg::BOARD_W,
  parameter int BOARD_H   = draw_pkg::BOARD_H,
  parameter int CELL_SIZE = draw_pkg::CELL_SIZE
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         load,
  input  logic                         advance,
  input  logic [4:0]                   row_lo_in,
  input  logic [4:0]                   row_hi_in,
  output logic [$clog2(CELL_SIZE)-1:0] ox,
  output logic [$clog2(CELL_SIZE)-1:0] oy,
  output logic [$clog2(BOARD_W)-1:0]   col,
  output logic [4:0]                   row,
  output logic                         last,
  output logic                         empty
);

  logic [4:0] hi_clamp;
  logic [4:0] hi_r;
  logic       ox_end;
  logic       oy_end;
  logic       col_end;

  assign hi_clamp = (32'(row_hi_in) > BOARD_H - 1) ? 5'(BOARD_H - 1) : row_hi_in;
  assign empty    = row_lo_in > hi_clamp;

  assign ox_end  = (32'(ox) == CELL_SIZE - 1);
  assign oy_end  = (32'(oy) == CELL_SIZE - 1);
  assign col_end = (32'(col) == BOARD_W - 1);
  assign last    = ox_end && oy_end && col_end && (row == hi_r);

  // ox is the fastest digit, row the slowest
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ox   <= '0;
      oy   <= '0;
      col  <= '0;
      row  <= '0;
      hi_r <= '0;
    end else if (load) begin
      ox   <= '0;
      oy   <= '0;
      col  <= '0;
      row  <= row_lo_in;
      hi_r <= hi_clamp;
    end else if (advance) begin
      if (!ox_end) begin
        ox <= ox + 1'b1;
      end else begin
        ox <= '0;
        if (!oy_end) begin
          oy <= oy + 1'b1;
        end else begin
          oy <= '0;
          if (!col_end) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            row <= row + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/draw_board_window.sv
// rtl/draw_board_window.sv - streams a band of board rows from RAM to the VGA plot port
// Defining DRAW_GRID_EN paints the right/bottom pixel edge of occupied cells in GRID_COLOUR.
module draw_board_window #(
  parameter int BOARD_W     = draw_pkg::BOARD_W,
  parameter int BOARD_H     = draw_pkg::BOARD_H,
  parameter int HIDDEN_ROWS = draw_pkg::HIDDEN_ROWS,
  parameter int CELL_SIZE   = draw_pkg::CELL_SIZE,
  parameter int X_START     = draw_pkg::X_START,
  parameter int Y_START     = draw_pkg::Y_START,
  parameter int COLOUR_W    = draw_pkg::COLOUR_W,
  parameter int ADDR_W      = 8,
  parameter int RAM_LATENCY = 1
`ifdef DRAW_GRID_EN
  , parameter logic [COLOUR_W-1:0] GRID_COLOUR = COLOUR_W'(6'b010101)
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic                clear,
  input  logic [4:0]          row_lo,
  input  logic [4:0]          row_hi,
  input  logic [COLOUR_W-1:0] ram_q,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  import draw_pkg::*;

  localparam int OXW = $clog2(CELL_SIZE);
  localparam int CW  = $clog2(BOARD_W);

  state_t                state, state_nxt;
  logic [OXW-1:0]        ox, oy;
  logic [CW-1:0]         col;
  logic [4:0]            row;
  logic                  last, empty, load, run;
  logic                  clear_r, drain_cnt;
  logic [7:0]            s0_x, d1_x, tail_x;
  logic [6:0]            s0_y, d1_y, tail_y;
  logic                  d1_valid, tail_valid;
  logic [COLOUR_W-1:0]   pix_colour, colour_hold;
`ifdef DRAW_GRID_EN
  logic                  s0_grid, d1_grid, tail_grid, grid_r;
`endif

  assign load = (state == IDLE) && start && !abort;
  assign run  = (state == RUN);
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  board_scan_counter #(
    .BOARD_W  (BOARD_W),
    .BOARD_H  (BOARD_H),
    .CELL_SIZE(CELL_SIZE)
  ) u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .advance  (run),
    .row_lo_in(row_lo),
    .row_hi_in(row_hi),
    .ox       (ox),
    .oy       (oy),
    .col      (col),
    .row      (row),
    .last     (last),
    .empty    (empty)
  );

  assign ram_addr = run ? ADDR_W'((32'(row) + HIDDEN_ROWS) * BOARD_W + 32'(col)) : '0;
  assign s0_x     = 8'(X_START + 32'(col) * CELL_SIZE + 32'(ox));
  assign s0_y     = 7'(Y_START + 32'(row) * CELL_SIZE + 32'(oy));

  // Coordinates travel alongside the RAM read so they land with the matching ram_q
  assign tail_valid = (RAM_LATENCY == 2) ? d1_valid : run;
  assign tail_x     = (RAM_LATENCY == 2) ? d1_x     : s0_x;
  assign tail_y     = (RAM_LATENCY == 2) ? d1_y     : s0_y;
`ifdef DRAW_GRID_EN
  assign s0_grid    = (32'(ox) == CELL_SIZE - 1) || (32'(oy) == CELL_SIZE - 1);
  assign tail_grid  = (RAM_LATENCY == 2) ? d1_grid : s0_grid;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = empty ? DONE : RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (last) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (32'(drain_cnt) == RAM_LATENCY - 1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_colour = clear_r ? COLOUR_W'(BLACK) : ram_q;
`ifdef DRAW_GRID_EN
    if (!clear_r && grid_r && (ram_q != '0)) pix_colour = GRID_COLOUR;
`endif
  end

  // ram_q is only valid in the plot cycle, so colour is muxed live and held otherwise
  assign colour = plot ? pix_colour : colour_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      drain_cnt   <= 1'b0;
      clear_r     <= 1'b0;
      d1_valid    <= 1'b0;
      d1_x        <= '0;
      d1_y        <= '0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour_hold <= '0;
`ifdef DRAW_GRID_EN
      d1_grid     <= 1'b0;
      grid_r      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 1'b0;
      if (load) clear_r <= clear;
      if (plot) colour_hold <= colour;
      if (abort) begin
        d1_valid <= 1'b0;
        plot     <= 1'b0;
      end else begin
        d1_valid <= run;
        d1_x     <= s0_x;
        d1_y     <= s0_y;
        plot     <= tail_valid;
`ifdef DRAW_GRID_EN
        d1_grid  <= s0_grid;
        if (tail_valid) grid_r <= tail_grid;
`endif
        if (tail_valid) begin
          x <= tail_x;
          y <= tail_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_board_window.sv
// tb/tb_draw_board_window.sv - directed table-driven bench for draw_board_window (latency 1 and 2)
module tb_draw_board_window;

  logic       clk = 1'b0;
  logic       resetn, start, abort, clear;
  logic [4:0] row_lo, row_hi;
  logic       ram_mode;

  logic [5:0] q1, q2, q2a;
  logic [7:0] addr1, addr2, x1, x2;
  logic [6:0] y1, y2;
  logic [5:0] colour1, colour2;
  logic       plot1, plot2, busy1, busy2, done1, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  draw_board_window dut1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .clear(clear),
    .row_lo(row_lo), .row_hi(row_hi), .ram_q(q1), .ram_addr(addr1),
    .x(x1), .y(y1), .colour(colour1), .plot(plot1), .busy(busy1), .done(done1)
  );

  draw_board_window #(.RAM_LATENCY(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .clear(clear),
    .row_lo(row_lo), .row_hi(row_hi), .ram_q(q2), .ram_addr(addr2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
  );

  function automatic logic [5:0] mem_val(input int a);
    logic [5:0] v;
    v = ram_mode ? 6'h2A : 6'(a * 7 + 3);
    return v;
  endfunction

  always @(posedge clk) begin
    q1  <= mem_val(int'(addr1));
    q2a <= mem_val(int'(addr2));
    q2  <= q2a;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference for pixel i of a band starting at row lo (default geometry)
  task automatic pix_model(input int lo, input int i, output int ex, output int ey, output int ea);
    int ox, oy, col, row;
    ox  = i % 4;
    oy  = (i / 4) % 4;
    col = (i / 16) % 10;
    row = lo + i / 160;
    ex  = 59 + col * 4 + ox;
    ey  = 11 + row * 4 + oy;
    ea  = (row + 4) * 10 + col;
  endtask

  typedef struct {
    int lo; int hi; bit clr; bit mode; int poke;
    int n; int done_c; int fx; int fy; int lx; int ly;
  } vec_t;

  vec_t tv[6];

  task automatic apply(input vec_t v, input string tag);
    int nplots = 0, done_c = -1, ndone = 0, err = 0, busy_c1 = 0;
    int first_c = -1, fx = -1, fy = -1, lx = -1, ly = -1;
    int first2_c = -1, first2_col = -1, addr2_c1 = -1;
    int ex, ey, ea, ec;
    @(negedge clk);
    row_lo = 5'(v.lo); row_hi = 5'(v.hi); clear = v.clr; ram_mode = v.mode; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      start = (c == v.poke);
      if (c == 1) begin
        busy_c1 = busy1;
        addr2_c1 = addr2;
      end
      if (c - 1 < v.n) begin
        pix_model(v.lo, c - 1, ex, ey, ea);
        if (addr1 != 8'(ea)) err++;
      end
      if (plot1) begin
        pix_model(v.lo, c - 2, ex, ey, ea);
        ec = v.clr ? 0 : int'(mem_val(ea));
        if (x1 != 8'(ex) || y1 != 7'(ey) || colour1 != 6'(ec)) err++;
        if (!busy1) err++;
        if (first_c < 0) begin first_c = c; fx = x1; fy = y1; end
        lx = x1; ly = y1;
        nplots++;
      end
      if (plot2 && first2_c < 0) begin
        first2_c = c;
        first2_col = colour2;
      end
      if (done1) begin
        ndone++;
        if (busy1) err++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    start = 1'b0;
    check({tag, "_plots"}, nplots, v.n);
    check({tag, "_done_cycle"}, done_c, v.done_c);
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_busy_c1"}, busy_c1, (v.n > 0) ? 1 : 0);
    if (v.n > 0) begin
      pix_model(v.lo, 0, ex, ey, ea);
      ec = v.clr ? 0 : int'(mem_val(ea));
      check({tag, "_first_cycle"}, first_c, 2);
      check({tag, "_first_x"}, fx, v.fx);
      check({tag, "_first_y"}, fy, v.fy);
      check({tag, "_last_x"}, lx, v.lx);
      check({tag, "_last_y"}, ly, v.ly);
      check({tag, "_pixel_errors"}, err, 0);
      check({tag, "_lat2_addr_c1"}, addr2_c1, ea);
      check({tag, "_lat2_first_cycle"}, first2_c, 3);
      check({tag, "_lat2_first_colour"}, first2_col, ec);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    //         lo  hi clr mode poke    n  done   fx  fy  lx  ly
    tv[0] = '{ 0, 19, 0, 0,  0, 3200, 3202, 59, 11, 98, 90};
    tv[1] = '{ 5,  5, 0, 1, 20,  160,  162, 59, 31, 98, 34};
    tv[2] = '{ 0,  0, 1, 0,  0,  160,  162, 59, 11, 98, 14};
    tv[3] = '{ 7,  3, 0, 0,  0,    0,    1,  0,  0,  0,  0};
    tv[4] = '{10, 25, 0, 0,  0, 1600, 1602, 59, 51, 98, 90};
    tv[5] = '{19, 19, 0, 1,  0,  160,  162, 59, 87, 98, 90};

    resetn = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0;
    row_lo = '0; row_hi = '0; ram_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_dut1", {plot1, busy1, done1, x1, y1, colour1, addr1}, 0);
    check("reset_outputs_dut2", {plot2, busy2, done2, x2, y2, colour2, addr2}, 0);
    resetn = 1'b1;

    for (int k = 0; k < 6; k++) apply(tv[k], $sformatf("vec%0d", k));

    // abort in IDLE with a simultaneous start must be ignored
    @(negedge clk);
    row_lo = 5'd0; row_hi = 5'd19; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy1, 0);
    check("idle_abort_done", done1, 0);

    // abort during a full redraw
    @(negedge clk);
    row_lo = 5'd0; row_hi = 5'd19; clear = 1'b0; ram_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    bad = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 50) begin
        check("abort_running_plot", plot1, 1);
        abort = 1'b1;
      end
      if (c == 51) begin
        abort = 1'b0;
        check("abort_plot_c51", plot1, 0);
        check("abort_busy_c51", busy1, 0);
      end
      if (c > 51 && (done1 || plot1 || done2 || plot2)) bad++;
      if (c >= 50 && done1) bad++;
    end
    check("abort_no_done_or_plot", bad, 0);
    apply(tv[2], "after_abort");

    // asynchronous reset mid-run
    @(negedge clk);
    row_lo = 5'd0; row_hi = 5'd19; clear = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_plotting", plot1 & plot2, 1);
    resetn = 1'b0;
    #1;
    check("async_reset_dut1", {plot1, busy1, done1, x1, y1, colour1, addr1}, 0);
    check("async_reset_dut2", {plot2, busy2, done2, x2, y2, colour2, addr2}, 0);
    @(negedge clk);
    resetn = 1'b1;
    apply(tv[5], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
